// File: rtl/plru_replace_ctrl.sv
// Tree-PLRU replacement controller for NUM_SETS sets of NUM_WAYS ways.
// Serialises TOUCH/ALLOCATE/INVALIDATE/FLUSH requests and returns a victim way
// for each ALLOCATE, preferring the lowest-index invalid way over the PLRU choice.
module plru_replace_ctrl #(
   parameter int unsigned NUM_WAYS = 4,
   parameter int unsigned NUM_SETS = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [1:0]                  req_op,
   input  logic [$clog2(NUM_SETS)-1:0] req_set,
   input  logic [$clog2(NUM_WAYS)-1:0] req_way,
   output logic                        resp_valid,
   output logic [$clog2(NUM_WAYS)-1:0] resp_way,
   output logic                        resp_evict
);

   localparam int unsigned WAY_W = $clog2(NUM_WAYS);
   localparam int unsigned SET_W = $clog2(NUM_SETS);

   localparam logic [1:0] OP_TOUCH = 2'b00;
   localparam logic [1:0] OP_ALLOC = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_FLUSH = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOOKUP = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q;
   logic [SET_W-1:0] set_q;
   logic [WAY_W-1:0] way_q;
   logic [SET_W-1:0] flush_cnt_q;

   // Tree bits use heap indices 1..NUM_WAYS-1; bit 0 is never written and stays 0.
   logic [NUM_WAYS-1:0] tree_mem  [NUM_SETS];
   logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];

   logic [NUM_WAYS-1:0] new_tree_q, new_valid_q;
   logic [WAY_W-1:0]    resp_way_q;
   logic                resp_evict_q;

   logic [NUM_WAYS-1:0] cur_tree, cur_valid;
   logic [NUM_WAYS-1:0] mru_tree;
   logic [NUM_WAYS-1:0] calc_tree, calc_valid;
   logic [WAY_W:0]      walk_node;
   logic [WAY_W:0]      mru_node;
   logic [WAY_W-1:0]    plru_way, inv_way, victim, mru_way, calc_way;
   logic                has_inv, calc_evict;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_way   = resp_way_q;
   assign resp_evict = resp_evict_q;

   // Victim selection and next set state for the latched request.
   always_comb begin
      cur_tree  = tree_mem[set_q];
      cur_valid = valid_mem[set_q];

      // PLRU walk: next node = 2*i + t[i], so shift the tree bit in at the bottom.
      walk_node = {{WAY_W{1'b0}}, 1'b1};
      for (int l = 0; l < int'(WAY_W); l++) begin
         walk_node = {walk_node[WAY_W-1:0], cur_tree[walk_node[WAY_W-1:0]]};
      end
      plru_way = walk_node[WAY_W-1:0];

      // Scan downward so the lowest-index invalid way wins.
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
         if (!cur_valid[w]) begin
            has_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      victim = has_inv ? inv_way : plru_way;

      // MRU update: each parent points away from the child we came from.
      mru_way  = (op_q == OP_ALLOC) ? victim : way_q;
      mru_tree = cur_tree;
      mru_node = {1'b1, mru_way};
      for (int l = 0; l < int'(WAY_W); l++) begin
         mru_tree[mru_node[WAY_W:1]] = ~mru_node[0];
         mru_node = {1'b0, mru_node[WAY_W:1]};
      end

      calc_tree  = cur_tree;
      calc_valid = cur_valid;
      calc_way   = '0;
      calc_evict = 1'b0;
      case (op_q)
         OP_TOUCH: begin
            calc_tree = mru_tree;
            calc_way  = way_q;
         end
         OP_ALLOC: begin
            calc_tree          = mru_tree;
            calc_valid[victim] = 1'b1;
            calc_way           = victim;
            calc_evict         = cur_valid[victim];
         end
         OP_INVAL: begin
            calc_valid[way_q] = 1'b0;
            calc_way          = way_q;
         end
         default: ;
      endcase
   end

   // FSM next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) state_d = (req_op == OP_FLUSH) ? ST_FLUSH : ST_LOOKUP;
         end
         ST_LOOKUP: state_d = ST_RESP;
         ST_FLUSH: begin
            if (flush_cnt_q == SET_W'(NUM_SETS - 1)) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, request latch, flush counter and registered response fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_TOUCH;
         set_q        <= '0;
         way_q        <= '0;
         flush_cnt_q  <= '0;
         new_tree_q   <= '0;
         new_valid_q  <= '0;
         resp_way_q   <= '0;
         resp_evict_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid) begin
            op_q  <= req_op;
            set_q <= req_set;
            way_q <= req_way;
         end
         if (state_q == ST_LOOKUP) begin
            new_tree_q   <= calc_tree;
            new_valid_q  <= calc_valid;
            resp_way_q   <= calc_way;
            resp_evict_q <= calc_evict;
         end
         if (state_q == ST_FLUSH) begin
            // Power-of-two set count: the counter wraps back to 0 after the last set.
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_cnt_q == SET_W'(NUM_SETS - 1)) begin
               resp_way_q   <= '0;
               resp_evict_q <= 1'b0;
            end
         end
      end
   end

   // Per-set storage: cleared on reset, one set per FLUSH cycle, written back in RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < int'(NUM_SETS); s++) begin
            tree_mem[s]  <= '0;
            valid_mem[s] <= '0;
         end
      end else if (state_q == ST_FLUSH) begin
         tree_mem[flush_cnt_q]  <= '0;
         valid_mem[flush_cnt_q] <= '0;
      end else if (state_q == ST_RESP && op_q != OP_FLUSH) begin
         tree_mem[set_q]  <= new_tree_q;
         valid_mem[set_q] <= new_valid_q;
      end
   end

endmodule

// File: tb/tb_plru_replace_ctrl.sv
// Self-checking bench for plru_replace_ctrl: a behavioural PLRU model feeds a
// scoreboard queue at accept time; a negedge monitor pops and compares responses.
module tb_plru_replace_ctrl;

   localparam int NW = 4;
   localparam int NS = 16;

   localparam logic [1:0] OP_TOUCH = 2'b00;
   localparam logic [1:0] OP_ALLOC = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_FLUSH = 2'b11;

   typedef struct {
      logic [1:0] op;
      logic [1:0] way;
      logic       evict;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [3:0] req_set;
   logic [1:0] req_way;
   logic       resp_valid;
   logic [1:0] resp_way;
   logic       resp_evict;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   bit   m_tree  [NS][2*NW];
   bit   m_valid [NS][NW];

   plru_replace_ctrl #(
      .NUM_WAYS(NW),
      .NUM_SETS(NS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_set   (req_set),
      .req_way   (req_way),
      .resp_valid(resp_valid),
      .resp_way  (resp_way),
      .resp_evict(resp_evict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic void model_clear();
      for (int s = 0; s < NS; s++) begin
         for (int i = 0; i < 2*NW; i++) m_tree[s][i] = 1'b0;
         for (int i = 0; i < NW; i++) m_valid[s][i] = 1'b0;
      end
   endfunction

   function automatic int model_walk(int s);
      int i = 1;
      while (i < NW) i = m_tree[s][i] ? 2*i + 1 : 2*i;
      return i - NW;
   endfunction

   function automatic void model_mru(int s, int w);
      int j = w + NW;
      while (j / 2 >= 1) begin
         m_tree[s][j/2] = (j % 2 == 0);
         j = j / 2;
      end
   endfunction

   function automatic exp_t model_apply(logic [1:0] op, int s, int w);
      exp_t e;
      int   v;
      e.op = op; e.way = 2'd0; e.evict = 1'b0;
      case (op)
         OP_TOUCH: begin
            model_mru(s, w);
            e.way = 2'(w);
         end
         OP_ALLOC: begin
            v = -1;
            for (int i = 0; i < NW; i++) if (!m_valid[s][i] && v < 0) v = i;
            if (v < 0) v = model_walk(s);
            e.evict = m_valid[s][v];
            m_valid[s][v] = 1'b1;
            model_mru(s, v);
            e.way = 2'(v);
         end
         OP_INVAL: begin
            m_valid[s][w] = 1'b0;
            e.way = 2'(w);
         end
         default: model_clear();
      endcase
      return e;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (resp_valid) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL resp_unexpected: resp_valid=1 with nothing outstanding, required 0 (t=%0t)",
                     $time);
         end else begin
            mon_e = sb_q.pop_front();
            if (resp_way !== mon_e.way) begin
               n_err++;
               $display("FAIL resp_way op=%0d: got %0d, required %0d (t=%0t)",
                        mon_e.op, resp_way, mon_e.way, $time);
            end
            if (mon_e.op == OP_ALLOC) begin
               n_vec++;
               if (resp_evict !== mon_e.evict) begin
                  n_err++;
                  $display("FAIL resp_evict way=%0d: got %0b, required %0b (t=%0t)",
                           mon_e.way, resp_evict, mon_e.evict, $time);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int k = 0;
      while (req_ready !== 1'b1 && k < 50) begin
         @(posedge clk); #1; k++;
      end
      if (k >= 50) begin
         n_vec++; n_err++;
         $display("FAIL ready_timeout: req_ready=%b after 50 cycles, required 1", req_ready);
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 60) begin
         @(negedge clk); #1; k++;
      end
      if (k >= 60) begin
         n_vec++; n_err++;
         $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic run_op(input logic [1:0] op, input int s, input int w);
      wait_ready();
      req_valid = 1'b1; req_op = op; req_set = 4'(s); req_way = 2'(w);
      sb_q.push_back(model_apply(op, s, w));
      @(posedge clk); #1;
      // Scramble fields after accept: the DUT must use its latched copy.
      req_valid = 1'b0;
      req_op = 2'($urandom); req_set = 4'($urandom); req_way = 2'($urandom);
      wait_drain();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_set = 4'd0; req_way = 2'd0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_resp_valid: got %b, required 0", resp_valid); end
      n_vec++; if (resp_way !== 2'd0) begin n_err++;
         $display("FAIL reset_resp_way: got %0d, required 0", resp_way); end
      n_vec++; if (resp_evict !== 1'b0) begin n_err++;
         $display("FAIL reset_resp_evict: got %b, required 0", resp_evict); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < NW; i++) run_op(OP_ALLOC, 3, 0);
   endtask

   task automatic test_plru();
      run_op(OP_ALLOC, 3, 0);
      run_op(OP_TOUCH, 3, 0);
      run_op(OP_ALLOC, 3, 0);
   endtask

   task automatic test_invalid_first();
      run_op(OP_INVAL, 3, 1);
      run_op(OP_ALLOC, 3, 0);
      // Tree untouched by INVALIDATE shows up in the next PLRU choice on a full set.
      run_op(OP_ALLOC, 3, 0);
   endtask

   task automatic test_set_isolation();
      run_op(OP_ALLOC, 5, 0);
      run_op(OP_ALLOC, 3, 0);
   endtask

   task automatic test_flush();
      wait_ready();
      req_valid = 1'b1; req_op = OP_FLUSH; req_set = 4'd3; req_way = 2'd1;
      sb_q.push_back(model_apply(OP_FLUSH, 0, 0));
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k <= NS; k++) begin
         @(negedge clk);
         n_vec++;
         if (req_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_ready cycle N+%0d: got %b, required 0", k, req_ready); end
         n_vec++;
         if (resp_valid !== (k == NS)) begin n_err++;
            $display("FAIL flush_resp_valid cycle N+%0d: got %b, required %b",
                     k, resp_valid, (k == NS)); end
      end
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1) begin n_err++;
         $display("FAIL flush_ready_after: got %b, required 1", req_ready); end
      wait_drain();
      run_op(OP_ALLOC, 3, 0);
   endtask

   task automatic test_handshake();
      int pulses = 0;
      wait_ready();
      req_valid = 1'b1; req_op = OP_ALLOC; req_set = 4'd7; req_way = 2'd0;
      sb_q.push_back(model_apply(OP_ALLOC, 7, 0));
      @(posedge clk); #1;
      req_op = OP_TOUCH; req_set = 4'd7; req_way = 2'd3;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) pulses++;
         if (k < 2) begin
            n_vec++;
            if (req_ready !== 1'b0) begin n_err++;
               $display("FAIL hs_ready cycle N+%0d: got %b, required 0", k, req_ready); end
         end
         if (k == 0) begin req_op = OP_INVAL; req_way = 2'd0; end
         if (k == 1) req_op = OP_FLUSH;
         // Drop valid before the IDLE cycle's edge so nothing further is accepted.
         if (k == 1) begin @(posedge clk); #1; req_valid = 1'b0; @(negedge clk);
            if (resp_valid === 1'b1) pulses++; k++; end
      end
      n_vec++;
      if (pulses !== 1) begin n_err++;
         $display("FAIL hs_resp_count: got %0d pulses, required 1", pulses); end
      wait_drain();
      run_op(OP_ALLOC, 7, 0);
      run_op(OP_ALLOC, 7, 0);
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops [4] = '{OP_ALLOC, OP_ALLOC, OP_TOUCH, OP_ALLOC};
      int last_acc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ready();
         req_valid = 1'b1; req_op = ops[i]; req_set = 4'd10; req_way = 2'd0;
         sb_q.push_back(model_apply(ops[i], 10, 0));
         @(posedge clk); #1;
         if (i > 0) begin
            n_vec++;
            if (cyc - last_acc !== 3) begin n_err++;
               $display("FAIL b2b_gap op %0d: got %0d cycles, required 3", i, cyc - last_acc); end
         end
         last_acc = cyc;
      end
      req_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_mid_flush();
      int pulses = 0;
      run_op(OP_ALLOC, 3, 0);
      run_op(OP_ALLOC, 9, 0);
      run_op(OP_ALLOC, 9, 0);
      wait_ready();
      req_valid = 1'b1; req_op = OP_FLUSH;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      if (resp_valid === 1'b1) pulses++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      n_vec++;
      if (req_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_flush_ready: got %b, required 1", req_ready); end
      n_vec++;
      if (resp_way !== 2'd0) begin n_err++;
         $display("FAIL rst_flush_resp_way: got %0d, required 0", resp_way); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses !== 0) begin n_err++;
         $display("FAIL rst_flush_resp: got %0d pulses, required 0", pulses); end
      for (int s = 0; s < NS; s++) run_op(OP_ALLOC, s, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, NW - 1));
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_plru();
      test_invalid_first();
      test_set_isolation();
      test_flush();
      test_handshake();
      test_back_to_back();
      test_random();
      test_reset_mid_flush();
      repeat (4) @(posedge clk);
      n_vec++;
      if (sb_q.size() != 0) begin n_err++;
         $display("FAIL sb_leftover: got %0d outstanding, required 0", sb_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
